// File: rtl/aes_dec_key_mem.sv
// Round key generator and 15 x 128-bit key memory for the AES decipher round (AES-128 / AES-256).
// Optional macro AES_KEY_MEM_MASK_EN hides round_key (reads 0) while an expansion is in progress.

module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] base_s;

    // Table entry 0 sits in the most significant byte.
    always_comb begin
        base_s = 11'd2047 - {data, 3'b000};
        subst  = SBOX_TABLE[base_s -: 8];
    end
endmodule

module aes_dec_key_mem #(
    parameter logic       AES_128_BIT_KEY = 1'h0,
    parameter logic       AES_256_BIT_KEY = 1'h1,
    parameter logic [3:0] AES128_ROUNDS   = 4'ha,
    parameter logic [3:0] AES256_ROUNDS   = 4'he
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GENERATE = 2'd1, ST_DONE = 2'd2} state_t;

    state_t         state_r, state_s;
    logic [255:0]   key_r;
    logic           keylen_r;
    logic [3:0]     round_ctr_r;
    logic [7:0]     rcon_r;
    logic           ready_r;
    logic [127:0]   key_mem_r [0:14];

    logic           is_256_s, rot_s, use_rcon_s;
    logic [3:0]     last_idx_s, prev_idx_s, prev2_idx_s;
    logic [127:0]   prev_key_s, base_key_s, new_key_s, rd_key_s;
    logic [31:0]    tail_s, sub_in_s, sub_out_s, t_s, w0_s, w1_s, w2_s, w3_s;
    logic [7:0]     rcon_next_s;

    function automatic logic [7:0] gf_double(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Next round key from the previous one (AES-128) or the previous two (AES-256).
    always_comb begin
        is_256_s    = (keylen_r == AES_256_BIT_KEY);
        last_idx_s  = is_256_s ? AES256_ROUNDS : AES128_ROUNDS;
        prev_idx_s  = (round_ctr_r == 4'd0) ? 4'd0 : round_ctr_r - 4'd1;
        prev2_idx_s = (round_ctr_r < 4'd2) ? 4'd0 : round_ctr_r - 4'd2;
        prev_key_s  = key_mem_r[prev_idx_s];
        base_key_s  = is_256_s ? key_mem_r[prev2_idx_s] : prev_key_s;
        rcon_next_s = gf_double(rcon_r);
        // AES-256 odd rounds substitute without rotation or rcon.
        rot_s       = !is_256_s || !round_ctr_r[0];
        tail_s      = prev_key_s[31:0];
        sub_in_s    = rot_s ? {tail_s[23:0], tail_s[31:24]} : tail_s;
        t_s         = sub_out_s ^ (rot_s ? {rcon_next_s, 24'h000000} : 32'h00000000);
        w0_s        = base_key_s[127:96] ^ t_s;
        w1_s        = base_key_s[95:64] ^ w0_s;
        w2_s        = base_key_s[63:32] ^ w1_s;
        w3_s        = base_key_s[31:0] ^ w2_s;
        use_rcon_s  = (state_r == ST_GENERATE) && rot_s && (round_ctr_r != 4'd0);
        if (round_ctr_r == 4'd0) begin
            new_key_s = key_r[255:128];
        end else if (is_256_s && (round_ctr_r == 4'd1)) begin
            new_key_s = key_r[127:0];
        end else begin
            new_key_s = {w0_s, w1_s, w2_s, w3_s};
        end
    end

    aes_sbox u_sbox0 (.data(sub_in_s[31:24]), .subst(sub_out_s[31:24]));
    aes_sbox u_sbox1 (.data(sub_in_s[23:16]), .subst(sub_out_s[23:16]));
    aes_sbox u_sbox2 (.data(sub_in_s[15:8]),  .subst(sub_out_s[15:8]));
    aes_sbox u_sbox3 (.data(sub_in_s[7:0]),   .subst(sub_out_s[7:0]));

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (init) begin
                    state_s = ST_GENERATE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GENERATE: begin
                if (round_ctr_r == last_idx_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_GENERATE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Key capture, one memory write per GENERATE cycle, ready flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_r       <= 256'h0;
            keylen_r    <= 1'b0;
            round_ctr_r <= 4'd0;
            rcon_r      <= 8'h8d;
            ready_r     <= 1'b1;
            for (int i = 0; i < 15; i++) begin
                key_mem_r[i] <= 128'h0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (init) begin
                        key_r       <= key;
                        keylen_r    <= keylen;
                        round_ctr_r <= 4'd0;
                        rcon_r      <= 8'h8d;
                        ready_r     <= 1'b0;
                        // Stale AES-256 tail entries must not survive into an AES-128 schedule.
                        if (keylen == AES_128_BIT_KEY) begin
                            for (int i = 11; i < 15; i++) begin
                                key_mem_r[i] <= 128'h0;
                            end
                        end
                    end
                end
                ST_GENERATE: begin
                    key_mem_r[round_ctr_r] <= new_key_s;
                    round_ctr_r            <= round_ctr_r + 4'd1;
                    if (use_rcon_s) begin
                        rcon_r <= rcon_next_s;
                    end
                end
                ST_DONE: ready_r <= 1'b1;
                default: ready_r <= 1'b1;
            endcase
        end
    end

    // Combinational read port; indices past the last round key read zero.
    always_comb begin
        if (round > last_idx_s) begin
            rd_key_s = 128'h0;
        end else begin
            rd_key_s = key_mem_r[round];
        end
`ifdef AES_KEY_MEM_MASK_EN
        round_key = ready_r ? rd_key_s : 128'h0;
`else
        round_key = rd_key_s;
`endif
    end

    assign ready = ready_r;
endmodule

// File: tb/tb_aes_dec_key_mem.sv
// Directed vector bench for aes_dec_key_mem: table of expansions/reads plus re-init and reset corner cases.

module tb_aes_dec_key_mem;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         init = 1'b0;
    logic [255:0] key = 256'h0;
    logic         keylen = 1'b0;
    logic [3:0]   round = 4'd0;
    logic [127:0] round_key;
    logic         ready;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [255:0] KEY_A   = {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeefcafef00d0123456789abcdef};
    localparam logic [255:0] KEY_F   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h55aa55aa55aa55aa55aa55aa55aa55aa};
    localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    typedef struct {
        bit           do_init;
        bit           kl;
        logic [255:0] k;
        logic [3:0]   rnd;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [19];

    aes_dec_key_mem dut (
        .clk(clk), .reset_n(reset_n), .init(init), .key(key), .keylen(keylen),
        .round(round), .round_key(round_key), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic read_check(input string nm, input logic [3:0] rnd, input logic [127:0] exp);
        round = rnd;
        #1;
        check($sformatf("%s r%0d", nm, rnd), round_key, exp);
    endtask

    // Starts an expansion, optionally re-pulses init with alt_key, and checks the ready-low length.
    task automatic run_expand(input logic kl, input logic [255:0] k, input int reinit_at,
                              input logic [255:0] alt_key);
        int n;
        @(negedge clk);
        key = k; keylen = kl; init = 1'b1;
        @(negedge clk);
        init = 1'b0; key = ~k; keylen = ~kl;
        n = 0;
        while (ready !== 1'b1 && n < 64) begin
            n++;
`ifdef AES_KEY_MEM_MASK_EN
            check("mask_while_busy", round_key, 128'h0);
`endif
            if (n == reinit_at) begin
                key = alt_key; keylen = kl; init = 1'b1;
            end else begin
                init = 1'b0;
            end
            @(negedge clk);
        end
        init = 1'b0;
        check("ready_low_cycles", 128'(n), kl ? 128'd16 : 128'd12);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, KEY_A,   4'd0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[1]  = '{1'b0, 1'b0, KEY_A,   4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        vecs[2]  = '{1'b0, 1'b0, KEY_A,   4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[3]  = '{1'b0, 1'b0, KEY_A,   4'd11, 128'h0};
        vecs[4]  = '{1'b0, 1'b0, KEY_A,   4'd15, 128'h0};
        vecs[5]  = '{1'b1, 1'b0, KEY_F,   4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[6]  = '{1'b0, 1'b0, KEY_F,   4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[7]  = '{1'b0, 1'b0, KEY_F,   4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[8]  = '{1'b1, 1'b1, KEY_256, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[9]  = '{1'b0, 1'b1, KEY_256, 4'd1,  128'h101112131415161718191a1b1c1d1e1f};
        vecs[10] = '{1'b0, 1'b1, KEY_256, 4'd2,  128'ha573c29fa176c498a97fce93a572c09c};
        vecs[11] = '{1'b0, 1'b1, KEY_256, 4'd3,  128'h1651a8cd0244beda1a5da4c10640bade};
        vecs[12] = '{1'b0, 1'b1, KEY_256, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        vecs[13] = '{1'b0, 1'b1, KEY_256, 4'd15, 128'h0};
        vecs[14] = '{1'b1, 1'b0, KEY_A,   4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[15] = '{1'b0, 1'b0, KEY_A,   4'd11, 128'h0};
        vecs[16] = '{1'b0, 1'b0, KEY_A,   4'd12, 128'h0};
        vecs[17] = '{1'b0, 1'b0, KEY_A,   4'd14, 128'h0};
        vecs[18] = '{1'b0, 1'b0, KEY_A,   4'd15, 128'h0};

        repeat (2) @(negedge clk);
        check("reset_ready", 128'(ready), 128'd1);
        read_check("reset", 4'd0, 128'h0);
        read_check("reset", 4'd10, 128'h0);
        read_check("reset", 4'd14, 128'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].do_init) begin
                run_expand(vecs[i].kl, vecs[i].k, 0, 256'h0);
            end
            read_check($sformatf("vec%0d", i), vecs[i].rnd, vecs[i].exp);
        end

        // Second init three cycles into an expansion must be ignored.
        run_expand(1'b0, KEY_A, 3, KEY_F);
        read_check("reinit", 4'd0, 128'h000102030405060708090a0b0c0d0e0f);
        read_check("reinit", 4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        read_check("reinit", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        @(negedge clk);
        check("reinit_idle_ready", 128'(ready), 128'd1);

        // Reset asserted at cycle 5 of an AES-256 expansion.
        @(negedge clk);
        key = KEY_256; keylen = 1'b1; init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (4) @(negedge clk);
        check("midexp_busy", 128'(ready), 128'd0);
        reset_n = 1'b0;
        #1;
        check("midexp_reset_ready", 128'(ready), 128'd1);
        read_check("midexp_reset", 4'd0, 128'h0);
        read_check("midexp_reset", 4'd1, 128'h0);
        read_check("midexp_reset", 4'd2, 128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        run_expand(1'b0, KEY_F, 0, 256'h0);
        read_check("after_reset", 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_check("after_reset", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
